// File: rtl/pc_pkg.sv
// Shared types and helpers for the parametrised program counter with return stack.
// Holds the PC operation encoding and the priority decode of the active-low controls.
package pc_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      PC_INC,
      PC_HOLD,
      PC_LDLO,
      PC_JMP,
      PC_CALL,
      PC_RET
   } pc_op_t;

   function automatic int sp_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Staging select needs at least one bit even when only one hitmp byte exists.
   function automatic int sel_width(input int bytes);
      return (bytes > 2) ? $clog2(bytes - 1) : 1;
   endfunction

   function automatic pc_op_t decode_op(input logic pc_in_n, input logic call_n,
                                        input logic ret_n, input logic pclo_n,
                                        input logic hold_n);
      if (!pc_in_n)      return PC_JMP;
      else if (!call_n)  return PC_CALL;
      else if (!ret_n)   return PC_RET;
      else if (!pclo_n)  return PC_LDLO;
      else if (!hold_n)  return PC_HOLD;
      else               return PC_INC;
   endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Control/data bus between the decoder and the program counter block.
// master drives D and the active-low controls; slave returns PC and stack status.
interface pc_stack_if
   import pc_pkg::*;
#(
   parameter int BYTES       = 2,
   parameter int STACK_DEPTH = 4
);

   logic [BYTE_W-1:0]                D;
   logic                             _pchitmp_in;
   logic [sel_width(BYTES)-1:0]      tmp_sel;
   logic                             _pclo_in;
   logic                             _pc_in;
   logic                             _call;
   logic                             _ret;
   logic                             _hold;
   logic [BYTE_W*BYTES-1:0]          PC;
   logic [sp_width(STACK_DEPTH)-1:0] sp;
   logic                             stack_full;
   logic                             stack_empty;
   logic                             stack_ovf;
   logic                             stack_unf;

   modport master (
      output D, _pchitmp_in, tmp_sel, _pclo_in, _pc_in, _call, _ret, _hold,
      input  PC, sp, stack_full, stack_empty, stack_ovf, stack_unf
   );

   modport slave (
      input  D, _pchitmp_in, tmp_sel, _pclo_in, _pc_in, _call, _ret, _hold,
      output PC, sp, stack_full, stack_empty, stack_ovf, stack_unf
   );

endinterface

// File: rtl/pc_ret_stack.sv
// Return-address LIFO with occupancy count and sticky overflow/underflow flags.
// Push on full or pop on empty leaves sp alone and only raises the matching flag.
module pc_ret_stack
   import pc_pkg::*;
#(
   parameter int STACK_DEPTH = 4,
   parameter int WIDTH       = 16
) (
   input  logic                             clk,
   input  logic                             _MR,
   input  logic                             push,
   input  logic                             pop,
   input  logic [WIDTH-1:0]                 din,
   output logic [WIDTH-1:0]                 dout,
   output logic [sp_width(STACK_DEPTH)-1:0] sp,
   output logic                             full,
   output logic                             empty,
   output logic                             ovf,
   output logic                             unf
);

   localparam int SPW = sp_width(STACK_DEPTH);
   localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [WIDTH-1:0] mem [2**AW];
   logic [AW-1:0]    wr_a;
   logic [AW-1:0]    rd_a;

   assign full  = (sp == SPW'(STACK_DEPTH));
   assign empty = (sp == '0);
   assign wr_a  = sp[AW-1:0];
   assign rd_a  = wr_a - AW'(1);
   assign dout  = mem[rd_a];

   always_ff @(posedge clk or negedge _MR) begin
      if (!_MR) begin
         sp  <= '0;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else if (push) begin
         if (full) ovf <= 1'b1;
         else      sp  <= sp + SPW'(1);
      end else if (pop) begin
         if (empty) unf <= 1'b1;
         else       sp  <= sp - SPW'(1);
      end
   end

   // Contents are don't-care after reset, so the storage has no reset term.
   always_ff @(posedge clk) begin
      if (_MR && push && !full) mem[wr_a] <= din;
   end

endmodule

// File: rtl/pc_stack.sv
// Program counter loaded a byte at a time, with staged upper bytes and a return stack.
// One PC operation per edge, chosen by fixed priority; staging writes are independent.
module pc_stack
   import pc_pkg::*;
#(
   parameter int                       BYTES       = 2,
   parameter int                       STACK_DEPTH = 4,
   parameter logic [BYTE_W*BYTES-1:0]  RESET_PC    = '0
) (
   input  logic       clk,
   input  logic       _MR,
   pc_stack_if.slave  bus
);

   localparam int PW = BYTE_W * BYTES;
   localparam int SW = sel_width(BYTES);

   logic [PW-1:0]                     pc;
   logic [PW-1:0]                     pc_inc;
   logic [PW-1:0]                     pc_nxt;
   logic [PW-1:0]                     ret_addr;
   logic [BYTES-2:0][BYTE_W-1:0]      hitmp;
   pc_op_t                            op;
   logic                              push;
   logic                              pop;

   assign op     = decode_op(bus._pc_in, bus._call, bus._ret, bus._pclo_in, bus._hold);
   assign pc_inc = pc + PW'(1);
   assign push   = (op == PC_CALL);
   assign pop    = (op == PC_RET);
   assign bus.PC = pc;

   always_comb begin
      pc_nxt = pc_inc;
      case (op)
         PC_HOLD:         pc_nxt = pc;
         PC_LDLO:         pc_nxt = {pc[PW-1:BYTE_W], bus.D};
         PC_JMP, PC_CALL: pc_nxt = {hitmp, bus.D};
         // A return with nothing stacked behaves as a plain increment.
         PC_RET:          pc_nxt = bus.stack_empty ? pc_inc : ret_addr;
         default:         pc_nxt = pc_inc;
      endcase
   end

   always_ff @(posedge clk or negedge _MR) begin
      if (!_MR) pc <= RESET_PC;
      else      pc <= pc_nxt;
   end

   // Selects at or beyond BYTES-1 match no byte and are dropped.
   always_ff @(posedge clk or negedge _MR) begin
      if (!_MR) begin
         hitmp <= '0;
      end else begin
         for (int i = 0; i < BYTES - 1; i++)
            if (!bus._pchitmp_in && bus.tmp_sel == SW'(i)) hitmp[i] <= bus.D;
      end
   end

   pc_ret_stack #(
      .STACK_DEPTH (STACK_DEPTH),
      .WIDTH       (PW)
   ) u_stack (
      .clk   (clk),
      ._MR   (_MR),
      .push  (push),
      .pop   (pop),
      .din   (pc_inc),
      .dout  (ret_addr),
      .sp    (bus.sp),
      .full  (bus.stack_full),
      .empty (bus.stack_empty),
      .ovf   (bus.stack_ovf),
      .unf   (bus.stack_unf)
   );

endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack: a 2-byte instance for the main sequence and a
// 3-byte instance for wide carry and upper staging byte selection.
module tb_pc_stack;

   localparam logic [5:0] C_NONE = 6'b000000;
   localparam logic [5:0] C_H    = 6'b100000;
   localparam logic [5:0] C_LO   = 6'b010000;
   localparam logic [5:0] C_JP   = 6'b001000;
   localparam logic [5:0] C_CL   = 6'b000100;
   localparam logic [5:0] C_RT   = 6'b000010;
   localparam logic [5:0] C_HD   = 6'b000001;

   typedef struct {
      string       nm;
      logic [23:0] pc;
      logic [2:0]  sp;
      logic        ovf;
      logic        unf;
   } exp_t;

   logic clk;
   logic mr_n;
   bit   clk_run;
   int   n_cmp;
   int   n_bad;
   exp_t qa[$];
   exp_t qb[$];

   pc_stack_if #(.BYTES(2), .STACK_DEPTH(4)) ifa ();
   pc_stack_if #(.BYTES(3), .STACK_DEPTH(4)) ifb ();

   pc_stack #(.BYTES(2), .STACK_DEPTH(4), .RESET_PC(16'h0000)) dut_a (
      .clk (clk),
      ._MR (mr_n),
      .bus (ifa)
   );

   pc_stack #(.BYTES(3), .STACK_DEPTH(4), .RESET_PC(24'h000000)) dut_b (
      .clk (clk),
      ._MR (mr_n),
      .bus (ifb)
   );

   // One hand pulse with reset held, then a free-running clock.
   initial begin
      clk = 1'b0;
      #20 clk = 1'b1;
      #5  clk = 1'b0;
      wait (clk_run);
      forever #5 clk = ~clk;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive_a(input logic [5:0] c, input logic [7:0] d, input logic sel);
      ifa._pchitmp_in = ~c[5];
      ifa._pclo_in    = ~c[4];
      ifa._pc_in      = ~c[3];
      ifa._call       = ~c[2];
      ifa._ret        = ~c[1];
      ifa._hold       = ~c[0];
      ifa.D           = d;
      ifa.tmp_sel     = sel;
   endtask

   task automatic drive_b(input logic [5:0] c, input logic [7:0] d, input logic sel);
      ifb._pchitmp_in = ~c[5];
      ifb._pclo_in    = ~c[4];
      ifb._pc_in      = ~c[3];
      ifb._call       = ~c[2];
      ifb._ret        = ~c[1];
      ifb._hold       = ~c[0];
      ifb.D           = d;
      ifb.tmp_sel     = sel;
   endtask

   task automatic push_exp(input bit to_b, input string nm, input logic [23:0] pc,
                           input logic [2:0] sp, input logic ovf, input logic unf);
      exp_t e;
      e.nm  = nm;
      e.pc  = pc;
      e.sp  = sp;
      e.ovf = ovf;
      e.unf = unf;
      if (to_b) qb.push_back(e);
      else      qa.push_back(e);
   endtask

   task automatic step_a(input string nm, input logic [5:0] c, input logic [7:0] d,
                         input logic sel, input logic [15:0] pc, input logic [2:0] sp,
                         input logic ovf, input logic unf);
      @(negedge clk);
      drive_a(c, d, sel);
      push_exp(1'b0, nm, {8'h00, pc}, sp, ovf, unf);
   endtask

   task automatic step_b(input string nm, input logic [5:0] c, input logic [7:0] d,
                         input logic sel, input logic [23:0] pc, input logic [2:0] sp);
      @(negedge clk);
      drive_b(c, d, sel);
      push_exp(1'b1, nm, pc, sp, 1'b0, 1'b0);
   endtask

   // Monitors: each rising edge presents a new PC; compare against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (qa.size() != 0) begin
            e = qa.pop_front();
            chk(e.nm, {8'h00, ifa.PC, ifa.sp, ifa.stack_full, ifa.stack_empty,
                       ifa.stack_ovf, ifa.stack_unf},
                      {e.pc, e.sp, e.sp == 3'd4, e.sp == 3'd0, e.ovf, e.unf});
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (qb.size() != 0) begin
            e = qb.pop_front();
            chk(e.nm, {1'b0, ifb.PC, ifb.sp, ifb.stack_full, ifb.stack_empty},
                      {1'b0, e.pc, e.sp, e.sp == 3'd4, e.sp == 3'd0});
         end
      end
   end

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      clk_run = 0;
      mr_n    = 1'bx;

      // Controls stay X while reset is asserted.
      #2 mr_n = 1'b0;
      #1;
      chk("rst_async_pc_a", 32'(ifa.PC), 32'h0000);
      chk("rst_async_st_a", {ifa.sp, ifa.stack_full, ifa.stack_empty, ifa.stack_ovf, ifa.stack_unf},
                            {3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
      chk("rst_async_pc_b", 32'(ifb.PC), 32'h000000);
      #27;
      chk("rst_clk_held_a", 32'(ifa.PC), 32'h0000);
      chk("rst_clk_held_b", 32'(ifb.PC), 32'h000000);

      #2;
      drive_a(C_NONE, 8'h00, 1'b0);
      drive_b(C_HD, 8'h00, 1'b0);
      mr_n = 1'b1;
      push_exp(1'b0, "release_inc", 24'h0001, 3'd0, 1'b0, 1'b0);
      push_exp(1'b1, "b_release_hold", 24'h000000, 3'd0, 1'b0, 1'b0);
      clk_run = 1;

      step_a("inc2",          C_NONE,      8'h00, 1'b0, 16'h0002, 3'd0, 0, 0);
      step_a("stage_ff_adv",  C_H,         8'hFF, 1'b0, 16'h0003, 3'd0, 0, 0);
      step_a("jump_ffaa",     C_JP,        8'hAA, 1'b0, 16'hFFAA, 3'd0, 0, 0);
      step_a("ldlo_fe",       C_LO,        8'hFE, 1'b0, 16'hFFFE, 3'd0, 0, 0);
      step_a("inc_ffff",      C_NONE,      8'h00, 1'b0, 16'hFFFF, 3'd0, 0, 0);
      step_a("inc_wrap",      C_NONE,      8'h00, 1'b0, 16'h0000, 3'd0, 0, 0);
      step_a("stage_12",      C_H,         8'h12, 1'b0, 16'h0001, 3'd0, 0, 0);
      step_a("stage_jump_old",C_H | C_JP,  8'h34, 1'b0, 16'h1234, 3'd0, 0, 0);
      step_a("jump_new_hi",   C_JP,        8'h00, 1'b0, 16'h3400, 3'd0, 0, 0);
      step_a("stage_00",      C_H,         8'h00, 1'b0, 16'h3401, 3'd0, 0, 0);
      step_a("jump_000f",     C_JP,        8'h0F, 1'b0, 16'h000F, 3'd0, 0, 0);
      step_a("stage_20",      C_H,         8'h20, 1'b0, 16'h0010, 3'd0, 0, 0);
      step_a("call_2000",     C_CL,        8'h00, 1'b0, 16'h2000, 3'd1, 0, 0);
      step_a("inc_2001",      C_NONE,      8'h00, 1'b0, 16'h2001, 3'd1, 0, 0);
      step_a("inc_2002",      C_NONE,      8'h00, 1'b0, 16'h2002, 3'd1, 0, 0);
      step_a("ret_0011",      C_RT,        8'h00, 1'b0, 16'h0011, 3'd0, 0, 0);
      step_a("call1",         C_CL,        8'h01, 1'b0, 16'h2001, 3'd1, 0, 0);
      step_a("call2",         C_CL,        8'h02, 1'b0, 16'h2002, 3'd2, 0, 0);
      step_a("call3",         C_CL,        8'h03, 1'b0, 16'h2003, 3'd3, 0, 0);
      step_a("call4_full",    C_CL,        8'h04, 1'b0, 16'h2004, 3'd4, 0, 0);
      step_a("call5_ovf",     C_CL,        8'h05, 1'b0, 16'h2005, 3'd4, 1, 0);
      step_a("ret4",          C_RT,        8'h00, 1'b0, 16'h2004, 3'd3, 1, 0);
      step_a("ret3",          C_RT,        8'h00, 1'b0, 16'h2003, 3'd2, 1, 0);
      step_a("ret2",          C_RT,        8'h00, 1'b0, 16'h2002, 3'd1, 1, 0);
      step_a("ret1",          C_RT,        8'h00, 1'b0, 16'h0012, 3'd0, 1, 0);
      step_a("ret_unf_inc",   C_RT,        8'h00, 1'b0, 16'h0013, 3'd0, 1, 1);
      step_a("hold1",         C_HD,        8'h00, 1'b0, 16'h0013, 3'd0, 1, 1);
      step_a("hold2",         C_HD,        8'h00, 1'b0, 16'h0013, 3'd0, 1, 1);
      step_a("hold3",         C_HD,        8'h00, 1'b0, 16'h0013, 3'd0, 1, 1);
      step_a("ldlo_over_hold",C_HD | C_LO, 8'h55, 1'b0, 16'h0055, 3'd0, 1, 1);
      step_a("call_2040",     C_CL,        8'h40, 1'b0, 16'h2040, 3'd1, 1, 1);
      step_a("jump_over_ret", C_JP | C_RT, 8'h77, 1'b0, 16'h2077, 3'd1, 1, 1);
      step_a("ret_0056",      C_RT,        8'h00, 1'b0, 16'h0056, 3'd0, 1, 1);
      step_a("call_over_ret", C_CL | C_RT, 8'h00, 1'b0, 16'h2000, 3'd1, 1, 1);
      step_a("ret_over_ldlo", C_RT | C_LO, 8'h99, 1'b0, 16'h0057, 3'd0, 1, 1);
      step_a("stage_sel_oob", C_H,         8'hEE, 1'b1, 16'h0058, 3'd0, 1, 1);
      step_a("jump_hi_kept",  C_JP,        8'h00, 1'b0, 16'h2000, 3'd0, 1, 1);

      @(negedge clk);
      drive_a(C_HD, 8'h00, 1'b0);

      step_b("b_stage0_ff",   C_H | C_HD,  8'hFF, 1'b0, 24'h000000, 3'd0);
      step_b("b_stage1_ff",   C_H | C_HD,  8'hFF, 1'b1, 24'h000000, 3'd0);
      step_b("b_jump_ffffff", C_JP,        8'hFF, 1'b0, 24'hFFFFFF, 3'd0);
      step_b("b_inc_wrap",    C_NONE,      8'h00, 1'b0, 24'h000000, 3'd0);
      step_b("b_stage1_ab",   C_H,         8'hAB, 1'b1, 24'h000001, 3'd0);
      step_b("b_jump_abffcd", C_JP,        8'hCD, 1'b0, 24'hABFFCD, 3'd0);
      step_b("b_call",        C_CL,        8'h00, 1'b0, 24'hABFF00, 3'd1);
      step_b("b_ret",         C_RT,        8'h00, 1'b0, 24'hABFFCE, 3'd0);

      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drain", 32'(qa.size() + qb.size()), 32'd0);

      // Mid-cycle reset clears the sticky flags without any clock edge.
      @(negedge clk);
      #1 mr_n = 1'b0;
      #1;
      chk("rst_mid_pc_a", 32'(ifa.PC), 32'h0000);
      chk("rst_mid_st_a", {ifa.sp, ifa.stack_empty, ifa.stack_ovf, ifa.stack_unf},
                          {3'd0, 1'b1, 1'b0, 1'b0});
      chk("rst_mid_pc_b", 32'(ifb.PC), 32'h000000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
